// File: rtl/plane_spawn_ctrl_pkg.sv
// plane_spawn_ctrl_pkg: shared constants, slot record and amount clamp for the plane spawner
package plane_spawn_ctrl_pkg;
   localparam int SCREEN_W = 160;
   localparam int NUM_SLOTS = 10;
   localparam int SPAWN_X = SCREEN_W - 1;
   localparam logic [6:0] Y_OFFSET = 7'd8;
   localparam logic [6:0] LFSR_SEED = 7'h5A;
   typedef struct packed {
      logic active;
      logic [7:0] x;
      logic [6:0] y;
   } slot_t;
   function automatic int eff_amount(input logic [3:0] amt, input int max_n);
      return amt == 4'd0 ? 1 : int'(amt) > max_n ? max_n : int'(amt);
   endfunction
endpackage

// File: rtl/plane_spawn_ctrl_lfsr7.sv
// lfsr7: 7-bit Fibonacci LFSR (x^7+x^6+1), steps every enabled cycle
module lfsr7
   import plane_spawn_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   output logic [6:0] q
);
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) q <= LFSR_SEED;
      else if (enable) q <= {q[5:0], q[6] ^ q[5]};
endmodule

// File: rtl/plane_spawn_ctrl.sv
// plane_spawn_ctrl: slot table of flying planes; moves, escapes, hits and spawns on frame ticks
module plane_spawn_ctrl #(
   parameter int NUM_SLOTS = plane_spawn_ctrl_pkg::NUM_SLOTS,
   parameter int SPAWN_X = plane_spawn_ctrl_pkg::SPAWN_X
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic                 tick,
   input  logic [3:0]           plane_amount,
   input  logic [1:0]           flying_rate,
   input  logic                 hit_valid,
   input  logic [3:0]           hit_index,
   input  logic [3:0]           rd_index,
   output logic [7:0]           rd_x,
   output logic [6:0]           rd_y,
   output logic                 rd_active,
   output logic [NUM_SLOTS-1:0] active_mask,
   output logic                 spawn_pulse,
   output logic [7:0]           escaped_count
);
   import plane_spawn_ctrl_pkg::slot_t;
   import plane_spawn_ctrl_pkg::Y_OFFSET;
   import plane_spawn_ctrl_pkg::eff_amount;
   slot_t slot_q [NUM_SLOTS];
   slot_t slot_d [NUM_SLOTS];
   logic [6:0] lfsr_q;
   logic [7:0] step, esc_d;
   logic free_ok, do_spawn;
   int n_act, free_i, esc_n, esc_sum;
   lfsr7 u_lfsr (.clk(clk), .resetn(resetn), .enable(enable), .q(lfsr_q));
   // Spawn decision uses pre-tick occupancy, so a slot freed this tick is never picked
   always_comb begin
      slot_d = slot_q;
      n_act = 0;
      esc_n = 0;
      free_ok = 1'b0;
      free_i = 0;
      step = 8'(flying_rate) + 8'd1;
      for (int i = 0; i < NUM_SLOTS; i++) n_act += int'(slot_q[i].active);
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (!slot_q[i].active) begin
            free_ok = 1'b1;
            free_i = i;
         end
      do_spawn = enable && tick && free_ok && n_act < eff_amount(plane_amount, NUM_SLOTS);
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (enable && hit_valid && hit_index == 4'(i) && slot_q[i].active) slot_d[i] = '0;
         else if (enable && tick && slot_q[i].active) begin
            if (slot_q[i].x < step) begin
               slot_d[i] = '0;
               esc_n++;
            end else slot_d[i].x = slot_q[i].x - step;
         end
         if (do_spawn && free_i == i) slot_d[i] = '{1'b1, 8'(SPAWN_X), (lfsr_q & 7'h3F) + Y_OFFSET};
      end
      esc_sum = int'(escaped_count) + esc_n;
      esc_d = esc_sum > 255 ? 8'd255 : 8'(esc_sum);
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
         spawn_pulse <= 1'b0;
         escaped_count <= '0;
      end else if (enable) begin
         slot_q <= slot_d;
         spawn_pulse <= do_spawn;
         escaped_count <= esc_d;
      end
   always_comb begin
      rd_x = '0;
      rd_y = '0;
      rd_active = 1'b0;
      active_mask = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         active_mask[i] = slot_q[i].active;
         if (rd_index == 4'(i)) begin
            rd_x = slot_q[i].x;
            rd_y = slot_q[i].y;
            rd_active = slot_q[i].active;
         end
      end
   end
endmodule

// File: tb/tb_plane_spawn_ctrl.sv
// tb_plane_spawn_ctrl: directed vectors with hand-computed expectations for plane_spawn_ctrl
module tb_plane_spawn_ctrl;
   logic clk = 1'b0, resetn, enable, tick, hit_valid, rd_active, spawn_pulse;
   logic [3:0] plane_amount, hit_index, rd_index;
   logic [1:0] flying_rate;
   logic [7:0] rd_x, escaped_count;
   logic [6:0] rd_y;
   logic [9:0] active_mask;
   int n_vec = 0, n_bad = 0;
   always #5 clk = ~clk;
   plane_spawn_ctrl dut (
      .clk(clk), .resetn(resetn), .enable(enable), .tick(tick),
      .plane_amount(plane_amount), .flying_rate(flying_rate),
      .hit_valid(hit_valid), .hit_index(hit_index), .rd_index(rd_index),
      .rd_x(rd_x), .rd_y(rd_y), .rd_active(rd_active), .active_mask(active_mask),
      .spawn_pulse(spawn_pulse), .escaped_count(escaped_count)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic ticks(input int n);
      tick = 1'b1;
      cyc(n);
      tick = 1'b0;
   endtask
   task automatic rd(input logic [3:0] i);
      rd_index = i;
      #1;
   endtask
   task automatic do_reset;
      resetn = 1'b0;
      enable = 1'b0;
      tick = 1'b0;
      hit_valid = 1'b0;
      cyc(2);
      resetn = 1'b1;
      cyc(1);
   endtask
   initial begin
      resetn = 1'b0; enable = 1'b0; tick = 1'b0; hit_valid = 1'b0;
      hit_index = 4'd0; rd_index = 4'd0; plane_amount = 4'd3; flying_rate = 2'd0;
      #3;
      chk("rst_mask", active_mask, 10'h000);
      chk("rst_esc", escaped_count, 8'd0);
      chk("rst_pulse", spawn_pulse, 1'b0);
      cyc(2);
      resetn = 1'b1;
      // frozen from reset: ticks and hits ignored, LFSR must still be at seed
      tick = 1'b1; hit_valid = 1'b1; hit_index = 4'd0;
      cyc(20);
      tick = 1'b0; hit_valid = 1'b0;
      chk("frz0_mask", active_mask, 10'h000);
      enable = 1'b1;
      ticks(1);
      chk("t1_mask", active_mask, 10'h001);
      rd(0);
      chk("t1_x0", rd_x, 8'd159);
      chk("t1_y0", rd_y, 7'd34);
      chk("t1_act0", rd_active, 1'b1);
      chk("t1_pulse", spawn_pulse, 1'b1);
      ticks(1);
      chk("t2_mask", active_mask, 10'h003);
      rd(1);
      chk("t2_y1", rd_y, 7'd61);
      rd(0);
      chk("t2_x0", rd_x, 8'd158);
      cyc(1);
      chk("t2_pulse_off", spawn_pulse, 1'b0);
      ticks(2);
      chk("t4_mask", active_mask, 10'h007);
      chk("t4_pulse", spawn_pulse, 1'b0);
      rd(0);
      chk("t4_x0", rd_x, 8'd156);
      plane_amount = 4'd1;
      ticks(1);
      chk("lower_mask", active_mask, 10'h007);
      chk("lower_pulse", spawn_pulse, 1'b0);
      hit_valid = 1'b1; hit_index = 4'd12;
      cyc(1);
      chk("hit12_mask", active_mask, 10'h007);
      hit_index = 4'd1;
      cyc(1);
      hit_valid = 1'b0;
      chk("hit1_mask", active_mask, 10'h005);
      plane_amount = 4'd3;
      ticks(1);
      chk("refill_mask", active_mask, 10'h007);
      chk("refill_pulse", spawn_pulse, 1'b1);
      rd(1);
      chk("refill_x1", rd_x, 8'd159);
      rd(0);
      chk("pre_frz_x0", rd_x, 8'd154);
      enable = 1'b0; tick = 1'b1; hit_valid = 1'b1; hit_index = 4'd0;
      cyc(20);
      tick = 1'b0; hit_valid = 1'b0;
      chk("frz_mask", active_mask, 10'h007);
      chk("frz_x0", rd_x, 8'd154);
      chk("frz_esc", escaped_count, 8'd0);
      do_reset();
      enable = 1'b1; plane_amount = 4'd10; flying_rate = 2'd0;
      ticks(10);
      chk("full_mask", active_mask, 10'h3FF);
      chk("full_pulse10", spawn_pulse, 1'b1);
      rd(12);
      chk("rd12_act", rd_active, 1'b0);
      chk("rd12_x", rd_x, 8'd0);
      ticks(1);
      chk("full_pulse11", spawn_pulse, 1'b0);
      ticks(1);
      chk("full_pulse12", spawn_pulse, 1'b0);
      chk("full_mask12", active_mask, 10'h3FF);
      do_reset();
      enable = 1'b1; plane_amount = 4'd1; flying_rate = 2'd3;
      ticks(40);
      rd(0);
      chk("fly_x3", rd_x, 8'd3);
      chk("fly_act", rd_active, 1'b1);
      ticks(1);
      chk("esc_mask", active_mask, 10'h000);
      chk("esc_cnt", escaped_count, 8'd1);
      ticks(1);
      chk("respawn_mask", active_mask, 10'h001);
      #2 resetn = 1'b0;
      #1;
      chk("arst_mask", active_mask, 10'h000);
      chk("arst_esc", escaped_count, 8'd0);
      chk("arst_pulse", spawn_pulse, 1'b0);
      chk("arst_rdx", rd_x, 8'd0);
      chk("arst_rdact", rd_active, 1'b0);
      resetn = 1'b1;
      ticks(1);
      chk("post_rst_mask", active_mask, 10'h001);
      chk("post_rst_x0", rd_x, 8'd159);
      do_reset();
      enable = 1'b1; plane_amount = 4'd1; flying_rate = 2'd3;
      ticks(40);
      chk("hx_x3", rd_x, 8'd3);
      hit_valid = 1'b1; hit_index = 4'd12;
      cyc(1);
      chk("hx12_mask", active_mask, 10'h001);
      hit_index = 4'd0; tick = 1'b1;
      cyc(1);
      tick = 1'b0; hit_valid = 1'b0;
      chk("hx_mask", active_mask, 10'h000);
      chk("hx_esc", escaped_count, 8'd0);
      do_reset();
      enable = 1'b1; plane_amount = 4'd0; flying_rate = 2'd0;
      ticks(3);
      chk("amt0_mask", active_mask, 10'h001);
      plane_amount = 4'd15;
      ticks(11);
      chk("amt15_mask", active_mask, 10'h3FF);
      chk("amt15_pulse", spawn_pulse, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
